// File: rtl/fios_operand_server.sv
// Operand server for the FIOS PE chain: serves B/P words on fetch strobes and collects result words.
// Latency: operand word appears one cycle after its fetch strobe; the first result word is valid the cycle after done_i.
// Backpressure: load_ready_o drops once both banks are full; the result stream holds data stable until res_ready_i.
module fios_operand_server #(
  parameter int s     = 16,
  parameter int WIDTH = 17
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             load_sel_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic             b_fetch_i,
  input  logic             p_fetch_i,
  output logic [WIDTH-1:0] b_word_o,
  output logic [WIDTH-1:0] p_word_o,
  input  logic             res_push_i,
  input  logic [WIDTH-1:0] res_word_i,
  input  logic             done_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_last_o,
  output logic             err_o
);

  // Pointers carry one extra bit so they can hold the value s ("bank full").
  localparam int AW  = (s > 1) ? $clog2(s) : 1;
  localparam int PW  = $clog2(s) + 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0]  S_CNT  = PW'(s);
  localparam logic [PW-1:0]  S_LAST = PW'(s - 1);
  localparam logic [PW1-1:0] S_TOT  = PW1'(s);

  typedef enum logic [1:0] {LOAD, READY, RUN, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] b_mem [s];
  logic [WIDTH-1:0] p_mem [s];
  logic [WIDTH-1:0] r_mem [s];
  logic [PW-1:0]    bl, pl, bf, pf, rp, d;

  logic             load_acc;
  logic             b_wr, p_wr, r_wr;
  logic             load_drop;
  logic [PW-1:0]    bl_nxt, pl_nxt, d_nxt;
  logic [PW1-1:0]   push_total;

  // Write enables and next-pointer values shared by the storage and the FSM.
  always_comb begin
    load_acc   = load_valid_i & load_ready_o;
    b_wr       = load_acc & ~load_sel_i & (bl != S_CNT);
    p_wr       = load_acc &  load_sel_i & (pl != S_CNT);
    load_drop  = load_acc & ~b_wr & ~p_wr;
    bl_nxt     = bl + PW'(b_wr);
    pl_nxt     = pl + PW'(p_wr);
    r_wr       = (state == RUN) & res_push_i & (rp != S_CNT);
    push_total = {1'b0, rp} + PW1'(res_push_i);
    d_nxt      = d + PW'(1);
  end

  // Operand and result storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock_i) begin
    if (b_wr) b_mem[bl[AW-1:0]] <= load_data_i;
    if (p_wr) p_mem[pl[AW-1:0]] <= load_data_i;
    if (r_wr) r_mem[rp[AW-1:0]] <= res_word_i;
  end

  // Control FSM with registered outputs: load, wait for start, serve/collect, drain results.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= LOAD;
      bl           <= '0;
      pl           <= '0;
      bf           <= '0;
      pf           <= '0;
      rp           <= '0;
      d            <= '0;
      load_ready_o <= 1'b1;
      b_word_o     <= '0;
      p_word_o     <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      res_last_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bl <= bl_nxt;
          pl <= pl_nxt;
          // A word aimed at an already full bank is dropped.
          if (load_drop) err_o <= 1'b1;
          // Starting before operands are complete is a protocol error.
          if (start_i) err_o <= 1'b1;
          if ((bl_nxt == S_CNT) && (pl_nxt == S_CNT)) begin
            state        <= READY;
            load_ready_o <= 1'b0;
          end
        end

        READY: begin
          if (start_i) begin
            state <= RUN;
            bf    <= '0;
            pf    <= '0;
            rp    <= '0;
          end
        end

        RUN: begin
          // Fetch pointers wrap so the outer loop can re-walk the operand.
          if (b_fetch_i) begin
            b_word_o <= b_mem[bf[AW-1:0]];
            bf       <= (bf == S_LAST) ? '0 : bf + PW'(1);
          end
          if (p_fetch_i) begin
            p_word_o <= p_mem[pf[AW-1:0]];
            pf       <= (pf == S_LAST) ? '0 : pf + PW'(1);
          end
          if (r_wr) rp <= rp + PW'(1);
          if (res_push_i && (rp == S_CNT)) err_o <= 1'b1;
          if (done_i) begin
            if (push_total != S_TOT) err_o <= 1'b1;
            state       <= DRAIN;
            d           <= '0;
            res_valid_o <= 1'b1;
            res_last_o  <= (s == 1);
            // Bypass covers a push to index 0 landing in the done cycle.
            res_data_o  <= (r_wr && (rp == '0)) ? res_word_i : r_mem[0];
          end
        end

        DRAIN: begin
          if (res_push_i || done_i) err_o <= 1'b1;
          if (res_ready_i) begin
            if (d == S_LAST) begin
              state        <= LOAD;
              res_valid_o  <= 1'b0;
              res_last_o   <= 1'b0;
              res_data_o   <= '0;
              bl           <= '0;
              pl           <= '0;
              load_ready_o <= 1'b1;
            end else begin
              d          <= d_nxt;
              res_data_o <= r_mem[d_nxt[AW-1:0]];
              res_last_o <= (d_nxt == S_LAST);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fios_operand_server.sv
// Bench for fios_operand_server with s=4, WIDTH=17: directed vector table plus randomized runs
// checked against a bank/queue model of the operand server.
module tb_fios_operand_server;

  localparam int S = 4;
  localparam int W = 17;

  logic         clock_i;
  logic         reset_i;
  logic         load_valid_i;
  logic         load_ready_o;
  logic         load_sel_i;
  logic [W-1:0] load_data_i;
  logic         start_i;
  logic         b_fetch_i;
  logic         p_fetch_i;
  logic [W-1:0] b_word_o;
  logic [W-1:0] p_word_o;
  logic         res_push_i;
  logic [W-1:0] res_word_i;
  logic         done_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [W-1:0] res_data_o;
  logic         res_last_o;
  logic         err_o;

  fios_operand_server #(.s(S), .WIDTH(W)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_sel_i   (load_sel_i),
    .load_data_i  (load_data_i),
    .start_i      (start_i),
    .b_fetch_i    (b_fetch_i),
    .p_fetch_i    (p_fetch_i),
    .b_word_o     (b_word_o),
    .p_word_o     (p_word_o),
    .res_push_i   (res_push_i),
    .res_word_i   (res_word_i),
    .done_i       (done_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_last_o   (res_last_o),
    .err_o        (err_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: operand banks, last expected fetch outputs, sticky error.
  logic [W-1:0] mb [S];
  logic [W-1:0] mp [S];
  logic [W-1:0] exp_b;
  logic [W-1:0] exp_p;
  logic         exp_err;

  typedef struct {
    logic         bf;
    logic         pf;
    logic         push;
    logic         done;
    logic         rdy;
    logic [W-1:0] word;
    logic [W-1:0] eb;
    logic [W-1:0] ep;
    logic         ev;
    logic [W-1:0] ed;
    logic         el;
    logic         elr;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_inputs();
    load_valid_i = 1'b0;
    load_sel_i   = 1'b0;
    load_data_i  = '0;
    start_i      = 1'b0;
    b_fetch_i    = 1'b0;
    p_fetch_i    = 1'b0;
    res_push_i   = 1'b0;
    res_word_i   = '0;
    done_i       = 1'b0;
    res_ready_i  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 32'(load_ready_o), 32'd1);
    check({tag, "_b_word"},     32'(b_word_o),     32'd0);
    check({tag, "_p_word"},     32'(p_word_o),     32'd0);
    check({tag, "_res_valid"},  32'(res_valid_o),  32'd0);
    check({tag, "_res_data"},   32'(res_data_o),   32'd0);
    check({tag, "_res_last"},   32'(res_last_o),   32'd0);
    check({tag, "_err"},        32'(err_o),        32'd0);
  endtask

  // Load both banks in a random interleaving with random gaps; optionally inject protocol errors.
  task automatic model_load(input bit fixed, input bit inject);
    int  ib = 0;
    int  ip = 0;
    bit  extra_done = 0;
    bit  extra;
    logic sel;
    for (int i = 0; i < S; i++) begin
      mb[i] = fixed ? W'(i + 1) : W'($urandom());
      mp[i] = fixed ? W'(i + 5) : W'($urandom());
    end
    while (ib < S || ip < S) begin
      if ($urandom_range(0, 2) == 0) begin
        load_valid_i = 1'b0;
        if (inject && $urandom_range(0, 3) == 0) begin
          start_i = 1'b1;
          exp_err = 1'b1;
        end
        step();
        start_i = 1'b0;
        check("load_gap_ready", 32'(load_ready_o), 32'd1);
        check("load_gap_err", 32'(err_o), 32'(exp_err));
        continue;
      end
      extra = inject && !extra_done && ((ib == S) != (ip == S)) && ($urandom_range(0, 1) == 1);
      load_valid_i = 1'b1;
      if (extra) begin
        sel          = (ib == S) ? 1'b0 : 1'b1;
        load_sel_i   = sel;
        load_data_i  = W'($urandom());
        extra_done   = 1;
        exp_err      = 1'b1;
      end else begin
        if (ib == S)      sel = 1'b1;
        else if (ip == S) sel = 1'b0;
        else              sel = 1'($urandom_range(0, 1));
        load_sel_i = sel;
        if (sel) begin
          load_data_i = mp[ip];
          ip++;
        end else begin
          load_data_i = mb[ib];
          ib++;
        end
      end
      step();
      load_valid_i = 1'b0;
      check("load_ready", 32'(load_ready_o), (ib == S && ip == S) ? 32'd0 : 32'd1);
      check("load_err", 32'(err_o), 32'(exp_err));
    end
  endtask

  // One run: random fetch strobes interleaved with npush result pushes, then done_i and a drain.
  task automatic model_run(input int npush, input bit done_push, input int nfetch, input bit noise);
    int bcnt = 0;
    int pcnt = 0;
    int pushed = 0;
    int pre;
    int i;
    int budget;
    logic [W-1:0] pq [$];
    logic [W-1:0] w;
    bit bsel, psel, psh, rdy;
    pre = done_push ? npush - 1 : npush;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("run_load_ready", 32'(load_ready_o), 32'd0);
    check("run_res_valid", 32'(res_valid_o), 32'd0);
    for (int c = 0; c < nfetch || pushed < pre; c++) begin
      bsel = 1'($urandom_range(0, 1));
      psel = 1'($urandom_range(0, 1));
      psh  = (pushed < pre) && ((c >= nfetch) || ($urandom_range(0, 1) == 1));
      w    = W'($urandom());
      b_fetch_i = bsel; p_fetch_i = psel; res_push_i = psh; res_word_i = w;
      step();
      clear_inputs();
      if (bsel) begin exp_b = mb[bcnt % S]; bcnt++; end
      if (psel) begin exp_p = mp[pcnt % S]; pcnt++; end
      if (psh) begin
        pushed++;
        if (pushed <= S) pq.push_back(w);
        else exp_err = 1'b1;
      end
      check("run_b_word", 32'(b_word_o), 32'(exp_b));
      check("run_p_word", 32'(p_word_o), 32'(exp_p));
      check("run_res_valid", 32'(res_valid_o), 32'd0);
      check("run_err", 32'(err_o), 32'(exp_err));
    end
    w = W'($urandom());
    done_i = 1'b1;
    if (done_push) begin res_push_i = 1'b1; res_word_i = w; end
    step();
    clear_inputs();
    if (done_push) begin
      pushed++;
      if (pushed <= S) pq.push_back(w);
    end
    if (pushed != S) exp_err = 1'b1;
    i = 0;
    budget = 0;
    while (i < S && budget < 50) begin
      check("drain_valid", 32'(res_valid_o), 32'd1);
      check("drain_last", 32'(res_last_o), (i == S - 1) ? 32'd1 : 32'd0);
      if (i < pq.size()) check("drain_data", 32'(res_data_o), 32'(pq[i]));
      check("drain_err", 32'(err_o), 32'(exp_err));
      rdy = ($urandom_range(0, 3) != 0);
      res_ready_i = rdy;
      if (noise) begin
        b_fetch_i = 1'($urandom_range(0, 1));
        p_fetch_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin res_push_i = 1'b1; res_word_i = W'($urandom()); exp_err = 1'b1; end
        if ($urandom_range(0, 7) == 0) begin done_i = 1'b1; exp_err = 1'b1; end
      end
      step();
      clear_inputs();
      if (rdy) i++;
      budget++;
      check("drain_b_hold", 32'(b_word_o), 32'(exp_b));
      check("drain_p_hold", 32'(p_word_o), 32'(exp_p));
    end
    if (i < S) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words, expected %0d", i, S);
    end
    check("post_drain_valid", 32'(res_valid_o), 32'd0);
    check("post_drain_load_ready", 32'(load_ready_o), 32'd1);
    check("post_drain_err", 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    clear_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    exp_b = '0; exp_p = '0; exp_err = 1'b0;
    check_reset_outputs("reset");

    // Directed run: B={1,2,3,4}, P={5,6,7,8}, fetches, pushes A..D with done on the 4th, stalled drain.
    //           bf    pf    push  done  rdy   word     eb     ep     ev    ed       el    elr
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,  17'd1, 17'd0, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17'h0,  17'd2, 17'd5, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17'h0,  17'd3, 17'd6, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'hA,  17'd4, 17'd6, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'hB,  17'd1, 17'd6, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'hC,  17'd2, 17'd6, 1'b0, 17'h0,  1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'hD,  17'd2, 17'd6, 1'b1, 17'hA,  1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h0,  17'd2, 17'd6, 1'b1, 17'hB,  1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0,  17'd2, 17'd6, 1'b1, 17'hB,  1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h0,  17'd2, 17'd6, 1'b1, 17'hC,  1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h0,  17'd2, 17'd6, 1'b1, 17'hD,  1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h0,  17'd2, 17'd6, 1'b0, 17'h0,  1'b0, 1'b1};

    model_load(1'b1, 1'b0);
    check("ready_state_load_ready", 32'(load_ready_o), 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b_fetch_i = tv[i].bf; p_fetch_i = tv[i].pf; res_push_i = tv[i].push;
      done_i = tv[i].done; res_ready_i = tv[i].rdy; res_word_i = tv[i].word;
      step();
      clear_inputs();
      check($sformatf("vec%0d_b_word", i), 32'(b_word_o), 32'(tv[i].eb));
      check($sformatf("vec%0d_p_word", i), 32'(p_word_o), 32'(tv[i].ep));
      check($sformatf("vec%0d_res_valid", i), 32'(res_valid_o), 32'(tv[i].ev));
      if (tv[i].ev) begin
        check($sformatf("vec%0d_res_data", i), 32'(res_data_o), 32'(tv[i].ed));
        check($sformatf("vec%0d_res_last", i), 32'(res_last_o), 32'(tv[i].el));
      end
      check($sformatf("vec%0d_load_ready", i), 32'(load_ready_o), 32'(tv[i].elr));
      check($sformatf("vec%0d_err", i), 32'(err_o), 32'd0);
    end
    exp_b = 17'd2;
    exp_p = 17'd6;

    // Short run: done after only 2 pushes.
    model_load(1'b0, 1'b0);
    model_run(2, 1'b0, 5, 1'b0);
    check("short_run_err", 32'(err_o), 32'd1);

    // Overlong run: 5 pushes before done, the 5th is dropped.
    model_load(1'b0, 1'b0);
    model_run(5, 1'b0, 4, 1'b0);

    // Reset in the middle of a run after two B fetches.
    model_load(1'b0, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_fetch_i = 1'b1;
      step();
      b_fetch_i = 1'b0;
      check("pre_reset_b_word", 32'(b_word_o), 32'(mb[i]));
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    exp_b = '0; exp_p = '0; exp_err = 1'b0;
    check_reset_outputs("midrun_reset");
    model_load(1'b0, 1'b0);
    model_run(4, 1'b1, 6, 1'b0);
    check("fresh_run_err", 32'(err_o), 32'd0);

    // Randomized runs with error injection and drain-phase noise.
    for (int k = 0; k < 8; k++) begin
      int np;
      np = (k % 4 == 0) ? int'($urandom_range(3, 5)) : S;
      model_load(1'b0, (k >= 4));
      model_run(np, 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), (k >= 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
